// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC/buffer enables and flushes for load-use,
// redirect, data-memory wait (with timeout) and the halt drain sequence.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    logic [1:0]        drain_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic mem_stall;
    logic load_use;
    logic timeout;
    logic stall_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign mem_stall = mem_access & ~mem_ready;
    assign load_use  = ex_memread & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign timeout   = mem_stall & (wait_cnt == WAIT_LAST);
    // The halt cycle itself also holds the PC but is not a stall.
    assign stall_inc = (state == RUN) &
                       (mem_stall | (~ex_halt & ~ex_redirect & load_use));

    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_en    = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (reset && !mem_stall) begin
            case (state)
                RUN: begin
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    if (ex_halt) begin
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_redirect) begin
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                    end
                end
                DRAIN: begin
                    id_ex_en    = 1'b1;
                    id_ex_flush = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            wait_cnt  <= '0;
            halted    <= 1'b0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (stall_inc)
                stall_cnt <= sat_inc(stall_cnt);
            case (state)
                RUN, DRAIN: begin
                    if (mem_stall) begin
                        if (timeout) begin
                            state    <= HALTED;
                            halted   <= 1'b1;
                            mem_err  <= 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                        if (state == RUN) begin
                            if (ex_halt) begin
                                state     <= DRAIN;
                                drain_cnt <= 2'd2;
                            end
                        end else if (drain_cnt == 2'd0) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 2'd1;
                        end
                    end
                end
                HALTED: wait_cnt <= '0;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: priority table plus multi-cycle
// sequences, with expected outputs queued at drive time and checked at negedge.
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] CTL_NONE   = 7'b0000000;
    localparam logic [6:0] CTL_ALL    = 7'b1111100;
    localparam logic [6:0] CTL_REDIR  = 7'b1111111;
    localparam logic [6:0] CTL_HALT   = 7'b0111111;
    localparam logic [6:0] CTL_BUBBLE = 7'b0011101;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_memread, ex_redirect, ex_halt, mem_access, mem_ready;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, halted, mem_err;
    logic [15:0] stall_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .ex_halt(ex_halt), .mem_access(mem_access), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       memread;
        logic [4:0] rd;
        logic       redirect;
        logic       halt;
        logic       access;
        logic       ready;
    } vin_t;

    typedef struct {
        string       tag;
        logic [6:0]  ctrl;
        logic        halted;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    typedef struct {
        string      tag;
        vin_t       v;
        logic [6:0] ctrl;
    } vec_t;

    exp_t sb[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_err = 0;

    // Reference model state (0=RUN, 1=DRAIN, 2=HALTED)
    int          m_state = 0;
    int          m_drain = 0;
    int          m_wait  = 0;
    logic        m_halted = 1'b0;
    logic        m_err    = 1'b0;
    logic [15:0] m_cnt    = 16'd0;

    function automatic vin_t mk(input logic rst_n, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic memread, input logic [4:0] rd, input logic redirect,
                                input logic halt, input logic access, input logic ready);
        vin_t v;
        v.rst_n = rst_n; v.rs1 = rs1; v.rs2 = rs2; v.memread = memread; v.rd = rd;
        v.redirect = redirect; v.halt = halt; v.access = access; v.ready = ready;
        return v;
    endfunction

    function automatic logic [6:0] model_ctrl(input vin_t v, input int st);
        logic ms, lu;
        ms = v.access & ~v.ready;
        lu = v.memread && (v.rd != 5'd0) && ((v.rd == v.rs1) || (v.rd == v.rs2));
        if (!v.rst_n || ms || st == 2) return CTL_NONE;
        if (st == 1) return CTL_BUBBLE;
        if (v.halt) return CTL_HALT;
        if (v.redirect) return CTL_REDIR;
        if (lu) return CTL_BUBBLE;
        return CTL_ALL;
    endfunction

    task automatic model_advance(input vin_t v);
        logic ms, lu;
        ms = v.access & ~v.ready;
        lu = v.memread && (v.rd != 5'd0) && ((v.rd == v.rs1) || (v.rd == v.rs2));
        if (!v.rst_n) begin
            m_state = 0; m_drain = 0; m_wait = 0;
            m_halted = 1'b0; m_err = 1'b0; m_cnt = 16'd0;
        end else if (m_state != 2) begin
            if (m_state == 0 && (ms || (!v.halt && !v.redirect && lu)) && m_cnt != 16'hFFFF)
                m_cnt = m_cnt + 16'd1;
            if (ms) begin
                if (m_wait == 14) begin
                    m_state = 2; m_halted = 1'b1; m_err = 1'b1; m_wait = 0;
                end else begin
                    m_wait = m_wait + 1;
                end
            end else begin
                m_wait = 0;
                if (m_state == 0) begin
                    if (v.halt) begin
                        m_state = 1; m_drain = 2;
                    end
                end else if (m_drain == 0) begin
                    m_state = 2; m_halted = 1'b1;
                end else begin
                    m_drain = m_drain - 1;
                end
            end
        end
    endtask

    task automatic step(input vin_t v, input string tag, input logic use_tab, input logic [6:0] tab_ctrl);
        exp_t e;
        @(posedge clk);
        #1;
        reset = v.rst_n; id_rs1 = v.rs1; id_rs2 = v.rs2; ex_memread = v.memread;
        ex_rd = v.rd; ex_redirect = v.redirect; ex_halt = v.halt;
        mem_access = v.access; mem_ready = v.ready;
        e.tag    = tag;
        e.ctrl   = use_tab ? tab_ctrl : model_ctrl(v, m_state);
        e.halted = m_halted;
        e.err    = m_err;
        e.cnt    = m_cnt;
        sb.push_back(e);
        model_advance(v);
    endtask

    task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            cur = sb.pop_front();
            chk(cur.tag, "ctrl", {25'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                                  if_id_flush, id_ex_flush}, {25'd0, cur.ctrl});
            chk(cur.tag, "halted", {31'd0, halted}, {31'd0, cur.halted});
            chk(cur.tag, "mem_err", {31'd0, mem_err}, {31'd0, cur.err});
            chk(cur.tag, "stall_cnt", {16'd0, stall_cnt}, {16'd0, cur.cnt});
        end
    end

    vin_t idle, rst0, stall, lu5;
    vec_t tab[11];

    initial begin
        idle  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        rst0  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stall = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
        lu5   = mk(1, 0, 5, 1, 5, 0, 0, 0, 0);

        tab[0]  = '{"idle",          idle,                              CTL_ALL};
        tab[1]  = '{"lu_rs2",        lu5,                               CTL_BUBBLE};
        tab[2]  = '{"lu_rs1",        mk(1, 7, 3, 1, 7, 0, 0, 0, 0),     CTL_BUBBLE};
        tab[3]  = '{"lu_rd0",        mk(1, 0, 0, 1, 0, 0, 0, 0, 0),     CTL_ALL};
        tab[4]  = '{"ld_nomatch",    mk(1, 1, 2, 1, 9, 0, 0, 0, 0),     CTL_ALL};
        tab[5]  = '{"match_noload",  mk(1, 9, 2, 0, 9, 0, 0, 0, 0),     CTL_ALL};
        tab[6]  = '{"redir_lu",      mk(1, 0, 5, 1, 5, 1, 0, 0, 0),     CTL_REDIR};
        tab[7]  = '{"halt_redir",    mk(1, 0, 5, 1, 5, 1, 1, 0, 0),     CTL_HALT};
        tab[8]  = '{"mstall_all",    mk(1, 0, 5, 1, 5, 1, 1, 1, 0),     CTL_NONE};
        tab[9]  = '{"ready_lu",      mk(1, 0, 5, 1, 5, 0, 0, 1, 1),     CTL_BUBBLE};
        tab[10] = '{"ready_plain",   mk(1, 0, 0, 0, 0, 0, 0, 1, 1),     CTL_ALL};

        reset = 1'b0; id_rs1 = '0; id_rs2 = '0; ex_memread = 1'b0; ex_rd = '0;
        ex_redirect = 1'b0; ex_halt = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        step(rst0, "reset", 1'b0, CTL_NONE);

        for (int i = 0; i < 11; i++) begin
            step(tab[i].v, tab[i].tag, 1'b1, tab[i].ctrl);
            step(rst0, {"rst_after_", tab[i].tag}, 1'b0, CTL_NONE);
        end

        // Load-use releases after one bubble
        step(lu5, "lu_seq", 1'b0, CTL_NONE);
        step(idle, "lu_release", 1'b0, CTL_NONE);
        step(idle, "lu_after", 1'b0, CTL_NONE);

        // Halt drain, no stalls
        step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), "halt_T", 1'b0, CTL_NONE);
        for (int i = 1; i <= 6; i++) step(idle, $sformatf("halt_T%0d", i), 1'b0, CTL_NONE);
        step(rst0, "rst_halted", 1'b0, CTL_NONE);

        // Halt drain with one mem_stall at T+2
        step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), "halts_T", 1'b0, CTL_NONE);
        step(idle, "halts_T1", 1'b0, CTL_NONE);
        step(stall, "halts_T2", 1'b0, CTL_NONE);
        for (int i = 3; i <= 6; i++) step(idle, $sformatf("halts_T%0d", i), 1'b0, CTL_NONE);
        step(rst0, "rst_halts", 1'b0, CTL_NONE);

        // Memory wait of three cycles
        for (int i = 0; i < 3; i++) step(stall, $sformatf("mwait%0d", i), 1'b0, CTL_NONE);
        step(mk(1, 0, 0, 0, 0, 0, 0, 1, 1), "mwait_done", 1'b0, CTL_NONE);
        step(idle, "mwait_after", 1'b0, CTL_NONE);
        step(rst0, "rst_mwait", 1'b0, CTL_NONE);

        // Timeout after 15 consecutive stall cycles
        for (int i = 0; i < 17; i++) step(stall, $sformatf("tmo%0d", i), 1'b0, CTL_NONE);
        step(idle, "tmo_hold0", 1'b0, CTL_NONE);
        step(idle, "tmo_hold1", 1'b0, CTL_NONE);
        step(rst0, "rst_tmo", 1'b0, CTL_NONE);

        // Reset pulled during DRAIN
        step(idle, "md_idle", 1'b0, CTL_NONE);
        step(lu5, "md_lu", 1'b0, CTL_NONE);
        step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), "md_halt", 1'b0, CTL_NONE);
        step(idle, "md_drain", 1'b0, CTL_NONE);
        step(rst0, "md_reset", 1'b0, CTL_NONE);
        step(idle, "md_run0", 1'b0, CTL_NONE);
        step(idle, "md_run1", 1'b0, CTL_NONE);

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
